memsync_xfer_engine: RTL and testbench



---
 rtl/memsync_xfer_engine.sv | 137 +++++++++++++
 tb/tb_memsync_xfer_engine.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memsync_xfer_engine.sv
// Allocation transfer engine: round-robin arbitration over per-bank allocate
// requests, optional writeback then fill on the backing-store port, then a sync pulse.
module memsync_xfer_engine #(
  parameter int BGWIDTH       = 2,
  parameter int BAWIDTH       = 2,
  parameter int CHWIDTH       = 6,
  parameter int ADDRWIDTH     = 17,
  localparam int BANKGROUPS    = 2**BGWIDTH,
  localparam int BANKSPERGROUP = 2**BAWIDTH
) (
  input  logic                                                    clk,
  input  logic                                                    reset_n,
  input  logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0]                alloc_req,
  input  logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0][ADDRWIDTH-1:0] RowId,
  input  logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0][ADDRWIDTH-1:0] evictRowId,
  input  logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0]                dirty,
  input  logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0][CHWIDTH-1:0]   cRowId,
  output logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0]                sync,
  output logic                                                    xfer_valid,
  input  logic                                                    xfer_ready,
  output logic                                                    xfer_dir,
  output logic [BGWIDTH+BAWIDTH-1:0]                              xfer_bank,
  output logic [ADDRWIDTH-1:0]                                    xfer_row,
  output logic [CHWIDTH-1:0]                                      xfer_crow,
  input  logic                                                    xfer_done,
  output logic                                                    busy
);

  localparam int IW = BGWIDTH + BAWIDTH;
  localparam int NB = BANKGROUPS * BANKSPERGROUP;

  typedef enum logic [2:0] {
    IDLE, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, SYNC, HOLD
  } state_t;

  state_t state, state_nxt;

  // Packed [bg][ba] arrays flatten so that bit/element index == bg*BANKSPERGROUP+ba.
  logic [NB-1:0]                req_flat;
  logic [NB-1:0]                dirty_flat;
  logic [NB-1:0][ADDRWIDTH-1:0] row_flat;
  logic [NB-1:0][ADDRWIDTH-1:0] evict_flat;
  logic [NB-1:0][CHWIDTH-1:0]   crow_flat;

  assign req_flat   = alloc_req;
  assign dirty_flat = dirty;
  assign row_flat   = RowId;
  assign evict_flat = evictRowId;
  assign crow_flat  = cRowId;

  logic [IW-1:0]        last;
  logic [IW-1:0]        grant_idx;
  logic [ADDRWIDTH-1:0] lat_row;
  logic [ADDRWIDTH-1:0] lat_evict;
  logic [CHWIDTH-1:0]   lat_crow;
  logic                 lat_dirty;

  logic          win_found;
  logic [IW-1:0] win_idx;

  // Search begins one past the last grant; the IW-bit add wraps modulo NB.
  always_comb begin
    logic [IW-1:0] cand;
    cand      = '0;
    win_found = 1'b0;
    win_idx   = last;
    for (int i = 1; i <= NB; i++) begin
      cand = last + IW'(i);
      if (!win_found && req_flat[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last      <= IW'(NB - 1);
      grant_idx <= '0;
      lat_row   <= '0;
      lat_evict <= '0;
      lat_crow  <= '0;
      lat_dirty <= 1'b0;
    end else if (state == IDLE && win_found) begin
      last      <= win_idx;
      grant_idx <= win_idx;
      lat_row   <= row_flat[win_idx];
      lat_evict <= evict_flat[win_idx];
      lat_crow  <= crow_flat[win_idx];
      lat_dirty <= dirty_flat[win_idx];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (win_found) state_nxt = dirty_flat[win_idx] ? WB_REQ : FILL_REQ;
      WB_REQ:    if (xfer_ready) state_nxt = WB_WAIT;
      WB_WAIT:   if (xfer_done)  state_nxt = FILL_REQ;
      FILL_REQ:  if (xfer_ready) state_nxt = FILL_WAIT;
      FILL_WAIT: if (xfer_done)  state_nxt = SYNC;
      SYNC:      state_nxt = HOLD;
      HOLD:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Outputs decode only the state register and grant latches, so reset clears them at once.
  logic          in_wb;
  logic          active;
  logic [NB-1:0] sync_flat;

  assign in_wb  = (state == WB_REQ) || (state == WB_WAIT);
  assign active = (state != IDLE);

  always_comb begin
    sync_flat = '0;
    if (state == SYNC) sync_flat[grant_idx] = 1'b1;
  end

  assign sync       = sync_flat;
  assign xfer_valid = (state == WB_REQ) || (state == FILL_REQ);
  assign xfer_dir   = in_wb;
  assign xfer_bank  = active ? grant_idx : '0;
  assign xfer_row   = in_wb ? lat_evict : (active ? lat_row : '0);
  assign xfer_crow  = active ? lat_crow : '0;
  assign busy       = active;

endmodule

// File: tb/tb_memsync_xfer_engine.sv
// Directed bench for memsync_xfer_engine: clean/dirty transfers, RR order,
// backpressure, async reset mid-transfer and post-grant input changes.
module tb_memsync_xfer_engine;

  logic                   clk;
  logic                   reset_n;
  logic [3:0][3:0]        alloc_req;
  logic [3:0][3:0][16:0]  RowId;
  logic [3:0][3:0][16:0]  evictRowId;
  logic [3:0][3:0]        dirty;
  logic [3:0][3:0][5:0]   cRowId;
  logic [3:0][3:0]        sync;
  logic                   xfer_valid;
  logic                   xfer_ready;
  logic                   xfer_dir;
  logic [3:0]             xfer_bank;
  logic [16:0]            xfer_row;
  logic [5:0]             xfer_crow;
  logic                   xfer_done;
  logic                   busy;

  int n_tests = 0;
  int n_fail  = 0;

  memsync_xfer_engine dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .alloc_req  (alloc_req),
    .RowId      (RowId),
    .evictRowId (evictRowId),
    .dirty      (dirty),
    .cRowId     (cRowId),
    .sync       (sync),
    .xfer_valid (xfer_valid),
    .xfer_ready (xfer_ready),
    .xfer_dir   (xfer_dir),
    .xfer_bank  (xfer_bank),
    .xfer_row   (xfer_row),
    .xfer_crow  (xfer_crow),
    .xfer_done  (xfer_done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n    = 1'b0;
    alloc_req  = '0;
    RowId      = '0;
    evictRowId = '0;
    dirty      = '0;
    cRowId     = '0;
    xfer_ready = 1'b0;
    xfer_done  = 1'b0;
    #12;
    chk("rst_valid", xfer_valid, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_sync",  sync, 0);
    chk("rst_dir",   xfer_dir, 0);
    chk("rst_bank",  xfer_bank, 0);
    chk("rst_row",   xfer_row, 0);
    chk("rst_crow",  xfer_crow, 0);
    step();
    reset_n = 1'b1;

    // Clean request on bank 0/0
    alloc_req[0][0] = 1'b1;
    RowId[0][0]     = 17'h1A2B3;
    cRowId[0][0]    = 6'd5;
    xfer_ready      = 1'b1;
    step();
    chk("c1_valid", xfer_valid, 1);
    chk("c1_dir",   xfer_dir, 0);
    chk("c1_row",   xfer_row, 32'h1A2B3);
    chk("c1_crow",  xfer_crow, 5);
    chk("c1_bank",  xfer_bank, 0);
    chk("c1_busy",  busy, 1);
    step();
    chk("c2_valid", xfer_valid, 0);
    chk("c2_sync",  sync, 0);
    xfer_done = 1'b1;
    step();
    xfer_done = 1'b0;
    chk("c3_sync", sync, 32'h0001);
    alloc_req[0][0] = 1'b0;
    step();
    chk("c4_sync", sync, 0);
    chk("c4_busy", busy, 1);
    step();
    chk("c5_busy", busy, 0);

    // Dirty request on bg=1/ba=2 (idx 6)
    alloc_req[1][2]  = 1'b1;
    evictRowId[1][2] = 17'h00777;
    RowId[1][2]      = 17'h1FFFF;
    dirty[1][2]      = 1'b1;
    cRowId[1][2]     = 6'd9;
    step();
    chk("d1_valid", xfer_valid, 1);
    chk("d1_dir",   xfer_dir, 1);
    chk("d1_row",   xfer_row, 32'h00777);
    chk("d1_bank",  xfer_bank, 6);
    chk("d1_crow",  xfer_crow, 9);
    step();
    RowId[1][2] = 17'h00000;
    chk("d2_valid", xfer_valid, 0);
    xfer_done = 1'b1;
    step();
    xfer_done = 1'b0;
    chk("d3_valid", xfer_valid, 1);
    chk("d3_dir",   xfer_dir, 0);
    chk("d3_row_latched", xfer_row, 32'h1FFFF);
    chk("d3_sync",  sync, 0);
    step();
    chk("d4_sync", sync, 0);
    xfer_done = 1'b1;
    step();
    xfer_done = 1'b0;
    chk("d5_sync", sync, 32'h0040);
    alloc_req[1][2] = 1'b0;
    dirty[1][2]     = 1'b0;
    step();
    step();
    chk("d7_busy", busy, 0);

    // Backpressure on bank 0/2, done pulse during FILL_REQ must be ignored
    alloc_req[0][2] = 1'b1;
    RowId[0][2]     = 17'h0ABCD;
    cRowId[0][2]    = 6'd3;
    xfer_ready      = 1'b0;
    step();
    for (int c = 0; c < 10; c++) begin
      chk("bp_valid", xfer_valid, 1);
      chk("bp_row",   xfer_row, 32'h0ABCD);
      xfer_done = (c == 3);
      step();
    end
    xfer_done = 1'b0;
    chk("bp_valid_end", xfer_valid, 1);
    xfer_ready = 1'b1;
    step();
    chk("bp_accept_valid", xfer_valid, 0);
    step();
    step();
    chk("bp_wait_busy", busy, 1);
    chk("bp_wait_sync", sync, 0);
    xfer_done = 1'b1;
    step();
    xfer_done = 1'b0;
    chk("bp_sync", sync, 32'h0004);
    alloc_req[0][2] = 1'b0;
    step();
    step();

    // Reset in FILL_WAIT; idx 5 and idx 12 both pending
    alloc_req[1][1] = 1'b1;
    alloc_req[3][0] = 1'b1;
    RowId[1][1]     = 17'h11111;
    RowId[3][0]     = 17'h0C0C0;
    step();
    chk("r_grant_bank", xfer_bank, 5);
    step();
    chk("r_fw_busy", busy, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("r_async_busy",  busy, 0);
    chk("r_async_valid", xfer_valid, 0);
    chk("r_async_sync",  sync, 0);
    chk("r_async_bank",  xfer_bank, 0);
    step();
    reset_n = 1'b1;
    step();
    chk("r_regrant_bank", xfer_bank, 5);
    chk("r_regrant_row",  xfer_row, 32'h11111);
    step();
    xfer_done = 1'b1;
    step();
    xfer_done = 1'b0;
    chk("r_sync", sync, 32'h0020);
    alloc_req[1][1] = 1'b0;
    alloc_req[3][0] = 1'b0;
    step();
    step();
    chk("r_idle_busy", busy, 0);

    // Fresh reset, then all 16 banks request at once
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    alloc_req = '1;
    for (int k = 0; k < 16; k++) begin
      step();
      chk("rr_bank", xfer_bank, k);
      step();
      xfer_done = 1'b1;
      step();
      xfer_done = 1'b0;
      chk("rr_sync", sync, 32'h1 << k);
      alloc_req[k / 4][k % 4] = 1'b0;
      step();
      step();
    end
    chk("rr_done_busy", busy, 0);

    // idx 15 was last: idx 3 wins over idx 15
    alloc_req[0][3] = 1'b1;
    alloc_req[3][3] = 1'b1;
    step();
    chk("rr_wrap_bank", xfer_bank, 3);
    step();
    xfer_done = 1'b1;
    step();
    xfer_done = 1'b0;
    chk("rr_wrap_sync", sync, 32'h0008);
    alloc_req[0][3] = 1'b0;
    step();
    step();
    step();
    chk("rr_next_bank", xfer_bank, 15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
